sdram_port_arbiter: RTL

Shares the single CPU/chipset port (`port1_*`) of the 96 MHz SDRAM controller between two requesters: client A (CPU) and client B (DMA/chipset). It latches the winning client's command, holds `port1_req` until the controller acks, and drops the request in time for the controller's next cycle start. It then returns data and a one-cycle ack pulse to that client. The block sits between the client logic and the SDRAM controller, in the same `clk_96` domain.

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_arb_wdog.sv | 26 ++
 rtl/sdram_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port-1 arbiter: FSM states, client ids, latched command.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   typedef enum logic {
      CLI_A = 1'b0,
      CLI_B = 1'b1
   } cli_t;

   typedef struct packed {
      logic        we;
      logic [22:0] addr;
      logic [1:0]  ds;
      logic [15:0] din;
   } arb_cmd_t;

   localparam logic [15:0] ARB_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/sdram_arb_wdog.sv
// Transaction watchdog: 10-bit up-counter, flags expired when it reaches TIMEOUT.
module sdram_arb_wdog #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic clk_96,
   input  logic init,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [9:0] LIMIT = 10'(TIMEOUT);

   logic [9:0] count;

   assign expired = (count == LIMIT);

   // Holds at the limit; the arbiter leaves ISSUE before a wrap could occur.
   always_ff @(posedge clk_96) begin
      if (init || clr)
         count <= '0;
      else if (en && !expired)
         count <= count + 10'd1;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter for SDRAM controller port 1 (CPU = A, DMA/chipset = B).
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed A priority.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ARB_IDLE  | no transaction; grant evaluated when ready
//   ARB_ISSUE | port1_req high, command held, waiting for port1_ack
//   ARB_RESP  | port1_req low, one-cycle ack pulse to the owner
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk_96,
   input  logic        init,
   input  logic        ready,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [22:0] a_addr,
   input  logic [1:0]  a_ds,
   input  logic [15:0] a_din,
   output logic        a_ack,
   output logic [15:0] a_dout,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [22:0] b_addr,
   input  logic [1:0]  b_ds,
   input  logic [15:0] b_din,
   output logic        b_ack,
   output logic [15:0] b_dout,
   output logic        port1_req,
   output logic        port1_we,
   output logic [22:0] port1_addr,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_din,
   input  logic        port1_ack,
   input  logic [15:0] port1_dout,
   output logic        err_timeout
);

   arb_state_t  state;
   cli_t        owner;
   cli_t        last_grant;
   cli_t        grant_cli;
   logic        grant_any;
   logic        expired;
   logic        done;
   logic [15:0] resp_data;
   arb_cmd_t    sel_cmd;

   assign grant_any = (state == ARB_IDLE) && ready && (a_req || b_req);

   always_comb begin
      grant_cli = a_req ? CLI_A : CLI_B;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      if (a_req && b_req)
         grant_cli = (last_grant == CLI_A) ? CLI_B : CLI_A;
`endif
   end

   always_comb begin
      if (grant_cli == CLI_A)
         sel_cmd = '{we: a_we, addr: a_addr, ds: a_ds, din: a_din};
      else
         sel_cmd = '{we: b_we, addr: b_addr, ds: b_ds, din: b_din};
   end

   // A real ack wins over a simultaneous watchdog expiry.
   assign done      = port1_ack || expired;
   assign resp_data = port1_ack ? port1_dout : ARB_TIMEOUT_DATA;

   sdram_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_96  (clk_96),
      .init    (init),
      .clr     (grant_any),
      .en      (state == ARB_ISSUE),
      .expired (expired)
   );

   always_ff @(posedge clk_96) begin
      if (init)
         last_grant <= CLI_B;
      else
         last_grant <= grant_any ? grant_cli : last_grant;
   end

   always_ff @(posedge clk_96) begin
      if (init) begin
         state       <= ARB_IDLE;
         owner       <= CLI_A;
         port1_req   <= 1'b0;
         port1_we    <= 1'b0;
         port1_addr  <= '0;
         port1_ds    <= '0;
         port1_din   <= '0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         a_dout      <= '0;
         b_dout      <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_any) begin
                  state      <= ARB_ISSUE;
                  owner      <= grant_cli;
                  port1_req  <= 1'b1;
                  port1_we   <= sel_cmd.we;
                  port1_addr <= sel_cmd.addr;
                  port1_ds   <= sel_cmd.ds;
                  port1_din  <= sel_cmd.din;
               end
            end
            ARB_ISSUE: begin
               if (done) begin
                  state     <= ARB_RESP;
                  port1_req <= 1'b0;
                  if (!port1_ack)
                     err_timeout <= 1'b1;
                  if (owner == CLI_A) begin
                     a_ack <= 1'b1;
                     if (!port1_we)
                        a_dout <= resp_data;
                  end else begin
                     b_ack <= 1'b1;
                     if (!port1_we)
                        b_dout <= resp_data;
                  end
               end
            end
            ARB_RESP: begin
               state <= ARB_IDLE;
               a_ack <= 1'b0;
               b_ack <= 1'b0;
            end
            default: begin
               state     <= ARB_IDLE;
               port1_req <= 1'b0;
               a_ack     <= 1'b0;
               b_ack     <= 1'b0;
            end
         endcase
      end
   end

endmodule
